// File: rtl/dac_spi_frame_driver_if.sv
// Sample handshake between the reservoir node datapath
// and the DAC SPI frame driver.
interface dac_spi_frame_driver_if #(
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output busy,
    output done
  );
endinterface

// File: rtl/dac_spi_frame_driver.sv
// Serialises samples into {config,data} SPI frames, MSB first,
// then strobes LDAC_N and pulses done.
module dac_spi_frame_driver #(
  parameter int         DATA_WIDTH        = 12,
  parameter logic [3:0] CONFIG_BITS       = 4'b0011,
  parameter int         CLK_DIV           = 4,
  parameter int         LDAC_PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  dac_spi_frame_driver_if.slave up,
  output logic DAC_CS_N,
  output logic DAC_SCLK,
  output logic DAC_DIN,
  output logic DAC_LDAC_N
);
  localparam int FW = DATA_WIDTH + 4;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int LW = $clog2(LDAC_PULSE_CYCLES + 1);
  localparam int BW = $clog2(FW);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LDAC_LOAD = LW'(LDAC_PULSE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(FW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    LDAC
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt, div_cnt_n;
  logic [LW-1:0]   ldac_cnt, ldac_cnt_n;
  logic [BW-1:0]   bit_cnt, bit_cnt_n;
  // Bits still to be sent; the MSB goes straight to DIN at accept.
  logic [FW-2:0]   rest, rest_n;
  logic            cs_n, cs_n_n;
  logic            sclk, sclk_n;
  logic            dout, dout_n;
  logic            ldac_n, ldac_n_n;
  logic            done_q, done_n;
  logic            ready_q, ready_n;
  logic            busy_q;

  // Next-state and next-output decode; every pin is registered below.
  always_comb begin
    state_n    = state;
    div_cnt_n  = div_cnt;
    ldac_cnt_n = ldac_cnt;
    bit_cnt_n  = bit_cnt;
    rest_n     = rest;
    cs_n_n     = cs_n;
    sclk_n     = sclk;
    dout_n     = dout;
    ldac_n_n   = ldac_n;
    ready_n    = ready_q;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (up.din_valid && ready_q) begin
          state_n   = SETUP;
          div_cnt_n = DIV_LOAD;
          bit_cnt_n = BIT_LOAD;
          rest_n    = {CONFIG_BITS[2:0], up.din};
          dout_n    = CONFIG_BITS[3];
          cs_n_n    = 1'b0;
          sclk_n    = 1'b0;
          ready_n   = 1'b0;
        end
      end
      SETUP: begin
        if (div_cnt == '0) begin
          state_n   = SHIFT;
          sclk_n    = 1'b1;
          div_cnt_n = DIV_LOAD;
        end else begin
          div_cnt_n = div_cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt != '0) begin
          div_cnt_n = div_cnt - 1'b1;
        end else if (sclk) begin
          sclk_n    = 1'b0;
          div_cnt_n = DIV_LOAD;
          if (bit_cnt != '0) begin
            dout_n = rest[FW-2];
            rest_n = {rest[FW-3:0], 1'b0};
          end
        end else if (bit_cnt == '0) begin
          state_n    = LDAC;
          cs_n_n     = 1'b1;
          dout_n     = 1'b0;
          ldac_n_n   = 1'b0;
          ldac_cnt_n = LDAC_LOAD;
        end else begin
          bit_cnt_n = bit_cnt - 1'b1;
          sclk_n    = 1'b1;
          div_cnt_n = DIV_LOAD;
        end
      end
      LDAC: begin
        if (ldac_cnt == '0) begin
          state_n  = IDLE;
          ldac_n_n = 1'b1;
          done_n   = 1'b1;
          ready_n  = 1'b1;
        end else begin
          ldac_cnt_n = ldac_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      ldac_cnt <= '0;
      bit_cnt  <= '0;
      rest     <= '0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      dout     <= 1'b0;
      ldac_n   <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_cnt_n;
      ldac_cnt <= ldac_cnt_n;
      bit_cnt  <= bit_cnt_n;
      rest     <= rest_n;
      cs_n     <= cs_n_n;
      sclk     <= sclk_n;
      dout     <= dout_n;
      ldac_n   <= ldac_n_n;
      done_q   <= done_n;
      ready_q  <= ready_n;
      busy_q   <= ~ready_n;
    end
  end

  assign up.din_ready = ready_q;
  assign up.busy      = busy_q;
  assign up.done      = done_q;
  assign DAC_CS_N     = cs_n;
  assign DAC_SCLK     = sclk;
  assign DAC_DIN      = dout;
  assign DAC_LDAC_N   = ldac_n;
endmodule

// File: tb/tb_dac_spi_frame_driver.sv
// Bench for dac_spi_frame_driver: two instances (default timing
// and CLK_DIV=1/LDAC=1) checked against a timeline model.
module tb_dac_spi_frame_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_spi_frame_driver_if #(.DATA_WIDTH(12)) if0 ();
  dac_spi_frame_driver_if #(.DATA_WIDTH(12)) if1 ();
  logic cs0, sc0, di0, ld0;
  logic cs1, sc1, di1, ld1;

  dac_spi_frame_driver u0 (
    .clk(clk), .rst(rst), .up(if0),
    .DAC_CS_N(cs0), .DAC_SCLK(sc0),
    .DAC_DIN(di0), .DAC_LDAC_N(ld0)
  );

  dac_spi_frame_driver #(
    .CLK_DIV(1), .LDAC_PULSE_CYCLES(1)
  ) u1 (
    .clk(clk), .rst(rst), .up(if1),
    .DAC_CS_N(cs1), .DAC_SCLK(sc1),
    .DAC_DIN(di1), .DAC_LDAC_N(ld1)
  );

  int checks = 0;
  int errors = 0;

  // {ready,busy,done,cs_n,sclk,din,ldac_n}
  logic [6:0]  act [2];
  logic        vld [2];
  logic [11:0] dn  [2];
  assign act[0] = {if0.din_ready, if0.busy, if0.done,
                   cs0, sc0, di0, ld0};
  assign act[1] = {if1.din_ready, if1.busy, if1.done,
                   cs1, sc1, di1, ld1};
  assign vld[0] = if0.din_valid;
  assign vld[1] = if1.din_valid;
  assign dn[0]  = if0.din;
  assign dn[1]  = if1.din;

  function automatic int dv(int k);
    return (k == 0) ? 4 : 1;
  endfunction
  function automatic int lv(int k);
    return (k == 0) ? 2 : 1;
  endfunction
  function automatic int tdone(int k);
    return 33 * dv(k) + lv(k) + 1;
  endfunction

  // Expected pins t cycles after the handshake cycle.
  function automatic logic [6:0] expv(
    bit a, int t, logic [15:0] f, int d, int l);
    int u, b, w;
    if (!a) return 7'b1001001;
    if (t <= 33 * d) begin
      u = t - 1;
      if (u < d) return {5'b01000, f[15], 1'b1};
      b = (u - d) / (2 * d);
      w = (u - d) % (2 * d);
      if (w < d) return {5'b01001, f[15-b], 1'b1};
      return {5'b01000, (b < 15) ? f[14-b] : f[0], 1'b1};
    end
    if (t <= 33 * d + l) return 7'b0101000;
    return 7'b1011001;
  endfunction

  bit          m_act [2];
  int          m_t   [2];
  logic [15:0] m_f   [2];
  int          t0    [2];
  int          acc_cnt [2];
  int          cyc = 0;

  // Model: track the position in the frame timeline.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] <= 1'b0;
        m_t[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if ((!m_act[k] || m_t[k] == tdone(k)) && vld[k]) begin
          m_act[k]   <= 1'b1;
          m_t[k]     <= 1;
          m_f[k]     <= {4'b0011, dn[k]};
          t0[k]      <= cyc;
          acc_cnt[k] <= acc_cnt[k] + 1;
        end else if (m_act[k]) begin
          if (m_t[k] == tdone(k)) m_act[k] <= 1'b0;
          else m_t[k] <= m_t[k] + 1;
        end
      end
      cyc <= cyc + 1;
    end
  end

  logic        p_sc [2] = '{1'b0, 1'b0};
  logic        p_cs [2] = '{1'b1, 1'b1};
  logic        p_di [2] = '{1'b0, 1'b0};
  logic        p_ld [2] = '{1'b1, 1'b1};
  logic [15:0] cap  [2];
  int cs_len [2], cs_hi [2], ld_len [2];
  int last_frame [2], last_cs [2], last_gap [2], last_ld [2];
  int done_cnt [2] = '{0, 0};
  int done_cyc [2];

  // Compare against the model and run protocol checks each cycle.
  always @(negedge clk) begin
    logic [6:0] e, s;
    for (int k = 0; k < 2; k++) begin
      s = act[k];
      e = expv(m_act[k] && !rst, m_t[k], m_f[k], dv(k), lv(k));
      checks++;
      if (s !== e) begin
        errors++;
        $display("FAIL pins dut%0d cyc=%0d got=%b exp=%b",
                 k, cyc, s, e);
      end
      checks++;
      if (s[3] && s[2]) begin
        errors++;
        $display("FAIL sclk_idle dut%0d cyc=%0d got=1 exp=0",
                 k, cyc);
      end
      checks++;
      if (!s[3] && !s[0]) begin
        errors++;
        $display("FAIL ldac_overlap dut%0d cyc=%0d got=0 exp=1",
                 k, cyc);
      end
      if (!s[3] && p_cs[k]) begin
        last_gap[k] = cs_hi[k];
        cs_len[k]   = 0;
        cap[k]      = '0;
      end
      if (s[2] && !p_sc[k]) begin
        checks++;
        if (s[1] !== p_di[k]) begin
          errors++;
          $display("FAIL din_stable dut%0d cyc=%0d got=%b exp=%b",
                   k, cyc, s[1], p_di[k]);
        end
        cap[k] = {cap[k][14:0], s[1]};
      end
      if (!s[3]) cs_len[k]++;
      if (s[3] && !p_cs[k]) begin
        last_cs[k]    = cs_len[k];
        last_frame[k] = int'(cap[k]);
        cs_hi[k]      = 0;
      end
      if (s[3]) cs_hi[k]++;
      if (!s[0] && p_ld[k]) ld_len[k] = 0;
      if (!s[0]) ld_len[k]++;
      if (s[0] && !p_ld[k]) last_ld[k] = ld_len[k];
      if (s[4]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
      p_sc[k] = s[2];
      p_cs[k] = s[3];
      p_di[k] = s[1];
      p_ld[k] = s[0];
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(int k, logic [11:0] v, logic en);
    if (k == 0) begin
      if0.din = v;
      if0.din_valid = en;
    end else begin
      if1.din = v;
      if1.din_valid = en;
    end
  endtask

  task automatic send(int k, logic [11:0] v, bit hold);
    int a, n;
    a = acc_cnt[k];
    n = 0;
    drive(k, v, 1'b1);
    while (acc_cnt[k] == a && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", int'(acc_cnt[k] != a), 1);
    if (!hold) drive(k, 12'($urandom), 1'b0);
  endtask

  task automatic wait_done(int k, int max);
    int n;
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (act[k][4]) break;
      if (n >= max) begin
        checks++;
        errors++;
        $display("FAIL done_timeout dut%0d got=none exp=done", k);
        break;
      end
    end
  endtask

  task automatic check_frame(int k, int f, int csl, int ldl, int lat);
    chk("frame", last_frame[k], f);
    chk("cs_low_len", last_cs[k], csl);
    chk("ldac_len", last_ld[k], ldl);
    chk("done_latency", done_cyc[k] - t0[k], lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] v, first;
    int dc, n;
    drive(0, 12'h000, 1'b0);
    drive(1, 12'h000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins0", int'(act[0]), 7'b1001001);
    chk("rst_pins1", int'(act[1]), 7'b1001001);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(0, 12'hABC, 0);
    wait_done(0, 300);
    @(negedge clk);
    #1;
    check_frame(0, 16'h3ABC, 132, 2, 135);

    repeat (3) @(posedge clk);
    #1;
    send(0, 12'h000, 0);
    wait_done(0, 300);
    drive(0, 12'hFFF, 1'b1);
    @(negedge clk);
    #1;
    check_frame(0, 16'h3000, 132, 2, 135);
    send(0, 12'hFFF, 0);
    chk("b2b_accept_cyc", t0[0], done_cyc[0]);
    wait_done(0, 300);
    @(negedge clk);
    #1;
    check_frame(0, 16'h3FFF, 132, 2, 135);
    chk("cs_gap", last_gap[0], 3);

    repeat (2) @(posedge clk);
    #1;
    first = 12'($urandom);
    dc = done_cnt[0];
    send(0, first, 1);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (if0.done) break;
      if0.din = 12'($urandom);
    end
    drive(0, 12'h000, 1'b0);
    @(negedge clk);
    #1;
    chk("hold_frame", last_frame[0], {4'h3, first});
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done_cnt", done_cnt[0] - dc, 1);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      v = 12'($urandom);
      send(0, v, 0);
      wait_done(0, 300);
      @(negedge clk);
      #1;
      chk("rand_frame", last_frame[0], {4'h3, v});
    end

    repeat (2) @(posedge clk);
    #1;
    send(0, 12'h6C3, 0);
    repeat (69) @(posedge clk);
    #1;
    chk("mid_cs", int'(cs0), 0);
    chk("mid_sclk", int'(sc0), 1);
    dc = done_cnt[0];
    rst = 1'b1;
    #1;
    chk("rst_cs", int'(cs0), 1);
    chk("rst_sclk", int'(sc0), 0);
    chk("rst_din", int'(di0), 0);
    chk("rst_ldac", int'(ld0), 1);
    chk("rst_flags", int'(act[0][6:4]), 3'b100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt[0] - dc, 0);
    chk("rst_no_ldac", int'(ld0), 1);
    v = 12'($urandom);
    send(0, v, 0);
    wait_done(0, 300);
    @(negedge clk);
    #1;
    check_frame(0, {4'h3, v}, 132, 2, 135);

    send(1, 12'h5A5, 0);
    wait_done(1, 100);
    @(negedge clk);
    #1;
    check_frame(1, 16'h35A5, 33, 1, 35);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
